wptr_full_gen: RTL and testbench
================================

Name: wptr_full_gen

Overview:
Write-side pointer and full-flag generator for the async FIFO. It is the write-domain counterpart of the read pointer/empty logic. It keeps a binary write address for the RAM and a registered Gray write pointer for crossing to the read domain. It compares against the read pointer after that pointer has been synchronized into the write domain, and from that comparison it produces full, almost-full, fill level and sticky overflow status.

Parameters:
- ADDRSIZE, 4: RAM address width. DEPTH = 2**ADDRSIZE. Legal range ADDRSIZE >= 2.
- AFULL_THRESH, 2: almost-full margin in entries. walmost_full asserts when level >= DEPTH - AFULL_THRESH. Legal range 1..DEPTH-1.

Ports:
- wclk  input  1  write clock.
- wrst_n  input  1  reset; synchronous to wclk, active-low.
- winc  input  1  write request; the write is accepted only when wfull=0.
- wq2_rptr  input  ADDRSIZE+1  read pointer, Gray-coded, already synchronized into the wclk domain.
- wovf_clr  input  1  clears wovf.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  level has reached the almost-full threshold, registered.
- waddr  output  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
- wptr  output  ADDRSIZE+1  Gray write pointer, registered, sent to the read-domain synchronizer.
- wlevel  output  ADDRSIZE+1  write-side fill count, 0..DEPTH, registered.
- wovf  output  1  sticky overflow: a write was attempted while full.

Behaviour:
- All state updates only on posedge wclk.
- Reset applies when wrst_n=0 at a wclk edge. Reset values: wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0. Reset overrides every other input, including in the middle of a fill or an overflow.
- Pointer next-state:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - wbin <= wbinnext and wptr <= wgraynext, updated together in the same cycle.
- Full flag:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull <= wfull_val. Full therefore asserts in the same cycle that wptr shows the DEPTH-th outstanding write.
  - Full deasserts one wclk after wq2_rptr changes. It is pessimistic only by the synchronizer lag; it never asserts late.
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr, combinational: bit[ADDRSIZE] = g[ADDRSIZE]; bit[i] = bit[i+1] ^ g[i].
  - wlevel <= wbinnext - rbin_s, modulo 2**(ADDRSIZE+1). wlevel is never greater than DEPTH.
- Almost-full: walmost_full <= ((wbinnext - rbin_s) >= DEPTH - AFULL_THRESH). It updates in the same cycle as wlevel.
- Overflow:
  - An overflow event is winc=1 while wfull=1. On that event wbin and wptr hold.
  - wovf sets on the cycle after the event and stays set until wovf_clr=1.
  - If the set and wovf_clr occur in the same cycle, set wins.
- Wrap-around: wbin rolls over from 2**(ADDRSIZE+1)-1 to 0 with no special handling. The MSB-inversion compare handles full detection across the wrap.
- Data written to the RAM is out of scope. The parent writes the RAM at waddr when winc & ~wfull.

Optional Feature:
- Macro: FIFO_WR_OVF_CNT_EN.
- When defined:
  - Adds output port wovf_cnt, width 8.
  - Saturating count of rejected writes (winc & wfull); holds at 255.
  - Cleared to 0 by reset or by wovf_clr.
  - If wovf_clr and a rejected write occur in the same cycle, the count becomes 1.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan (ADDRSIZE=4, DEPTH=16, AFULL_THRESH=2):
1. Hold wrst_n=0 for 2 cycles with winc=1 -> wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
2. Fill: wq2_rptr=0, winc=1 for 16 cycles.
   - wptr sequence is 00001, 00011, 00010, 00110, ...
   - walmost_full=1 after the 14th write, when wlevel=14.
   - After the 16th write: wfull=1, wptr=11000, wlevel=16, waddr=0.
3. While full, winc=1 for 3 cycles -> wptr stays 11000, wovf=1. With the macro, wovf_cnt=3.
   - Then wovf_clr=1 together with winc=1 -> wovf stays 1.
   - Then wovf_clr=1 alone -> wovf=0.
4. Drain: set wq2_rptr=00110 (binary 4) -> next cycle wfull=0, wlevel=12, walmost_full=0. Then 4 writes -> wfull=1 again.
5. Wrap: preload to wbin=31 with wq2_rptr=11000 (binary 16), so wlevel=15. One write -> wbin=0, wptr=00000, wfull=1, wlevel=16.
6. Drive wrst_n=0 for one cycle during the fill of scenario 2 after 7 writes -> all outputs return to reset values. Full is next reached only after 16 further writes.

Source files
------------

// File: rtl/wptr_full_gen.sv
// Write-side pointer and full/almost-full/level/overflow generator for an async FIFO.
// Optional rejected-write counter output wovf_cnt is enabled by defining FIFO_WR_OVF_CNT_EN.
module wptr_full_gen #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wlevel,
`ifdef FIFO_WR_OVF_CNT_EN
  output logic [7:0]          wovf_cnt,
`endif
  output logic                wovf
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_LEVEL = (ADDRSIZE+1)'(DEPTH - AFULL_THRESH);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              wovf_q, wovf_d;
  logic [ADDRSIZE:0] rbin_s;
  logic              winc_ok;
  logic              ovf_evt;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all Gray bits at or above i.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_rbin
      assign rbin_s[gi] = ^(wq2_rptr >> gi);
    end
  endgenerate

  assign winc_ok = winc & ~wfull_q;
  assign ovf_evt = winc & wfull_q;

  always_comb begin
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, winc_ok};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    // Full when the next Gray pointer equals the read pointer with its two MSBs inverted.
    wfull_d        = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AFULL_LEVEL);
    wovf_d         = ovf_evt | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

`ifdef FIFO_WR_OVF_CNT_EN
  logic [7:0] wovf_cnt_q, wovf_cnt_d;

  // A rejected write in the same cycle as a clear restarts the count at one.
  always_comb begin
    wovf_cnt_d = wovf_cnt_q;
    if (ovf_evt) begin
      if (wovf_clr) begin
        wovf_cnt_d = 8'd1;
      end else if (wovf_cnt_q != 8'hFF) begin
        wovf_cnt_d = wovf_cnt_q + 8'd1;
      end
    end else if (wovf_clr) begin
      wovf_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wovf_cnt_q <= 8'd0;
    end else begin
      wovf_cnt_q <= wovf_cnt_d;
    end
  end

  assign wovf_cnt = wovf_cnt_q;
`endif

  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed bench for wptr_full_gen at ADDRSIZE=4, DEPTH=16, AFULL_THRESH=2.
// Checks wovf_cnt too when FIFO_WR_OVF_CNT_EN is defined.
module tb_wptr_full_gen;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic [4:0] wlevel;
  logic       wovf;
`ifdef FIFO_WR_OVF_CNT_EN
  logic [7:0] wovf_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  wptr_full_gen #(.ADDRSIZE(4), .AFULL_THRESH(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wovf_clr     (wovf_clr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .waddr        (waddr),
    .wptr         (wptr),
    .wlevel       (wlevel),
`ifdef FIFO_WR_OVF_CNT_EN
    .wovf_cnt     (wovf_cnt),
`endif
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = 5'd0;
    step();
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = 5'd0;
    step(); step();
    tests_run++;
    if ({wptr, waddr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got wptr=%b waddr=%0d wfull=%b afull=%b wlevel=%0d wovf=%b, want all 0",
               wptr, waddr, wfull, walmost_full, wlevel, wovf);
    end
`ifdef FIFO_WR_OVF_CNT_EN
    tests_run++;
    if (wovf_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d want 0", wovf_cnt);
    end
`endif
    $display("[TB] reset: wptr=%b wlevel=%0d", wptr, wlevel);
  endtask

  task automatic test_fill();
    logic [4:0] gtab [4];
    gtab = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};
    wrst_n = 1'b1; wq2_rptr = 5'd0; winc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      $display("[TB] fill write %0d: wptr=%b wlevel=%0d afull=%b full=%b", k, wptr, wlevel, walmost_full, wfull);
      if (k <= 4) begin
        tests_run++;
        if (wptr !== gtab[k-1]) begin
          tests_failed++;
          $display("FAIL fill_wptr_%0d: got %b want %b", k, wptr, gtab[k-1]);
        end
      end
      if (k == 13 || k == 14) begin
        tests_run++;
        if (walmost_full !== (k == 14) || wlevel !== 5'(k)) begin
          tests_failed++;
          $display("FAIL fill_afull_%0d: got afull=%b wlevel=%0d want afull=%b wlevel=%0d",
                   k, walmost_full, wlevel, (k == 14), k);
        end
      end
      if (k == 15) begin
        tests_run++;
        if (wfull !== 1'b0) begin
          tests_failed++;
          $display("FAIL fill_notfull_15: got wfull=%b want 0", wfull);
        end
      end
    end
    tests_run++;
    if (wfull !== 1'b1 || wptr !== 5'b11000 || wlevel !== 5'd16 || waddr !== 4'd0) begin
      tests_failed++;
      $display("FAIL fill_full: got wfull=%b wptr=%b wlevel=%0d waddr=%0d want 1 11000 16 0",
               wfull, wptr, wlevel, waddr);
    end
  endtask

  task automatic test_overflow();
    winc = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      $display("[TB] overflow attempt %0d: wptr=%b wovf=%b", k, wptr, wovf);
      tests_run++;
      if (wptr !== 5'b11000 || wovf !== 1'b1 || wfull !== 1'b1) begin
        tests_failed++;
        $display("FAIL ovf_hold_%0d: got wptr=%b wovf=%b wfull=%b want 11000 1 1", k, wptr, wovf, wfull);
      end
    end
`ifdef FIFO_WR_OVF_CNT_EN
    tests_run++;
    if (wovf_cnt !== 8'd3) begin
      tests_failed++;
      $display("FAIL ovf_cnt3: got %0d want 3", wovf_cnt);
    end
`endif
    wovf_clr = 1'b1; winc = 1'b1;
    step();
    $display("[TB] clr+write while full: wovf=%b", wovf);
    tests_run++;
    if (wovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: got wovf=%b want 1", wovf);
    end
`ifdef FIFO_WR_OVF_CNT_EN
    tests_run++;
    if (wovf_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL ovf_cnt_restart: got %0d want 1", wovf_cnt);
    end
`endif
    winc = 1'b0;
    step();
    $display("[TB] clr alone: wovf=%b", wovf);
    tests_run++;
    if (wovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got wovf=%b want 0", wovf);
    end
`ifdef FIFO_WR_OVF_CNT_EN
    tests_run++;
    if (wovf_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL ovf_cnt_clear: got %0d want 0", wovf_cnt);
    end
`endif
    wovf_clr = 1'b0;
    step();
    tests_run++;
    if (wovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_stays_clear: got wovf=%b want 0", wovf);
    end
  endtask

  task automatic test_drain();
    winc = 1'b0; wq2_rptr = 5'b00110;
    step();
    $display("[TB] drain rptr=4: wfull=%b wlevel=%0d afull=%b", wfull, wlevel, walmost_full);
    tests_run++;
    if (wfull !== 1'b0 || wlevel !== 5'd12 || walmost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain: got wfull=%b wlevel=%0d afull=%b want 0 12 0", wfull, wlevel, walmost_full);
    end
    winc = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      $display("[TB] refill write %0d: wlevel=%0d full=%b", k, wlevel, wfull);
      tests_run++;
      if (wfull !== (k == 4) || wlevel !== 5'(12 + k)) begin
        tests_failed++;
        $display("FAIL refill_%0d: got wfull=%b wlevel=%0d want %b %0d", k, wfull, wlevel, (k == 4), 12 + k);
      end
    end
    tests_run++;
    if (wptr !== 5'b11110 || waddr !== 4'd4) begin
      tests_failed++;
      $display("FAIL refill_ptr: got wptr=%b waddr=%0d want 11110 4", wptr, waddr);
    end
    winc = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    winc = 1'b1;
    // Read pointer trails each write by one so the FIFO never fills while wbin walks to 31.
    for (int i = 0; i < 31; i++) begin
      wq2_rptr = bin2gray(5'(i));
      step();
    end
    winc = 1'b0; wq2_rptr = 5'b11000;
    step();
    $display("[TB] wrap preload: wptr=%b wlevel=%0d full=%b", wptr, wlevel, wfull);
    tests_run++;
    if (wptr !== 5'b10000 || wlevel !== 5'd15 || wfull !== 1'b0 || waddr !== 4'd15) begin
      tests_failed++;
      $display("FAIL wrap_preload: got wptr=%b wlevel=%0d wfull=%b waddr=%0d want 10000 15 0 15",
               wptr, wlevel, wfull, waddr);
    end
    winc = 1'b1;
    step();
    winc = 1'b0;
    $display("[TB] wrap write: wptr=%b wlevel=%0d full=%b", wptr, wlevel, wfull);
    tests_run++;
    if (wptr !== 5'b00000 || waddr !== 4'd0 || wfull !== 1'b1 || wlevel !== 5'd16) begin
      tests_failed++;
      $display("FAIL wrap: got wptr=%b waddr=%0d wfull=%b wlevel=%0d want 00000 0 1 16",
               wptr, waddr, wfull, wlevel);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    winc = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    tests_run++;
    if (wptr !== 5'b00100 || wlevel !== 5'd7) begin
      tests_failed++;
      $display("FAIL midfill_7: got wptr=%b wlevel=%0d want 00100 7", wptr, wlevel);
    end
    wrst_n = 1'b0;
    step();
    $display("[TB] reset mid-fill: wptr=%b wlevel=%0d", wptr, wlevel);
    tests_run++;
    if ({wptr, waddr, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
      tests_failed++;
      $display("FAIL midfill_reset: got wptr=%b waddr=%0d wfull=%b afull=%b wlevel=%0d wovf=%b want all 0",
               wptr, waddr, wfull, walmost_full, wlevel, wovf);
    end
    wrst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15 || k == 16) begin
        tests_run++;
        if (wfull !== (k == 16)) begin
          tests_failed++;
          $display("FAIL refill_after_reset_%0d: got wfull=%b want %b", k, wfull, (k == 16));
        end
      end
    end
    $display("[TB] refill after reset: wptr=%b wlevel=%0d full=%b", wptr, wlevel, wfull);
    winc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
